// File: rtl/result_collector.sv
// Collects non-stallable lane result pulses into a round-robin-fed output FIFO
// and tracks the best score/ID of the running query.
module result_collector #(
    parameter int SCORE_WIDTH = 12,
    parameter int ID_WIDTH    = 48,
    parameter int LANES       = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int ZERO        = 2 ** (SCORE_WIDTH - 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [0:LANES*SCORE_WIDTH-1]      in_score,
    input  logic [0:LANES*ID_WIDTH-1]         in_id,
    input  logic [0:LANES-1]                  in_vld,
    input  logic                              query_done,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SCORE_WIDTH-1:0]            out_score,
    output logic [ID_WIDTH-1:0]               out_id,
    output logic [$clog2(LANES)-1:0]          out_lane,
    output logic                              max_vld,
    output logic [ID_WIDTH+SCORE_WIDTH-1:0]   max_out,
    output logic                              max_none,
    output logic                              overflow,
    output logic                              fifo_full
);

    localparam int LANE_W  = $clog2(LANES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = LANE_W + SCORE_WIDTH + ID_WIDTH;

    logic [SCORE_WIDTH-1:0] lane_score [LANES];
    logic [ID_WIDTH-1:0]    lane_id    [LANES];

    logic [SCORE_WIDTH-1:0] hold_score_q [LANES];
    logic [ID_WIDTH-1:0]    hold_id_q    [LANES];
    logic [LANES-1:0]       pend_q, pend_d;
    logic [LANES-1:0]       load;

    logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [LANE_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                   overflow_q, overflow_d;

    logic                   rd_en, wr_en, can_grant;
    logic                   grant_vld;
    logic [LANE_W-1:0]      grant_idx;
    logic [LANES-1:0]       gnt_oh;
    logic [ENTRY_W-1:0]     wr_entry, head;

    logic                   seen_q, seen_d;
    logic [SCORE_WIDTH-1:0] best_score_q;
    logic [ID_WIDTH-1:0]    best_id_q;
    logic                   cand_found, take_cand, eff_seen;
    logic [SCORE_WIDTH-1:0] cand_score, eff_score;
    logic [ID_WIDTH-1:0]    cand_id, eff_id;

    logic                   max_vld_q, max_vld_d;
    logic                   max_none_q, max_none_d;
    logic [ID_WIDTH+SCORE_WIDTH-1:0] max_out_q, max_out_d;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_score[i] = in_score[i*SCORE_WIDTH +: SCORE_WIDTH];
            lane_id[i]    = in_id[i*ID_WIDTH +: ID_WIDTH];
        end
    end

    // A read in the same cycle frees the full slot, so the grant may proceed.
    assign out_valid = (count_q != '0);
    assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
    assign rd_en     = out_valid && out_ready;
    assign can_grant = !fifo_full || rd_en;

    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        gnt_oh    = '0;
        for (int k = 0; k < LANES; k++) begin
            j = int'(rr_ptr_q) + k;
            if (j >= LANES) begin
                j = j - LANES;
            end
            if (!grant_vld && pend_q[j] && can_grant) begin
                grant_vld = 1'b1;
                grant_idx = LANE_W'(j);
                gnt_oh[j] = 1'b1;
            end
        end
    end

    assign wr_en    = grant_vld;
    assign wr_entry = {grant_idx, hold_score_q[grant_idx], hold_id_q[grant_idx]};

    // A lane being granted this cycle can take a new pulse; otherwise a busy lane drops it.
    always_comb begin
        pend_d     = pend_q;
        load       = '0;
        overflow_d = overflow_q;
        for (int i = 0; i < LANES; i++) begin
            if (in_vld[i]) begin
                if (!pend_q[i] || gnt_oh[i]) begin
                    load[i]   = 1'b1;
                    pend_d[i] = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (gnt_oh[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            rr_ptr_d = (grant_idx == LANE_W'(LANES - 1)) ? '0 : grant_idx + LANE_W'(1);
        end
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_lane  = out_valid ? head[ENTRY_W-1 -: LANE_W] : '0;
    assign out_score = out_valid ? head[ID_WIDTH +: SCORE_WIDTH] : '0;
    assign out_id    = out_valid ? head[ID_WIDTH-1:0] : '0;

    // Max tracker sees raw pulses, including ones the capture stage drops.
    always_comb begin
        cand_found = 1'b0;
        cand_score = '0;
        cand_id    = '0;
        for (int i = 0; i < LANES; i++) begin
            if (in_vld[i] && (!cand_found || lane_score[i] > cand_score)) begin
                cand_found = 1'b1;
                cand_score = lane_score[i];
                cand_id    = lane_id[i];
            end
        end
        take_cand = cand_found && (!seen_q || cand_score > best_score_q);
        eff_seen  = seen_q || cand_found;
        eff_score = take_cand ? cand_score : best_score_q;
        eff_id    = take_cand ? cand_id : best_id_q;
    end

    always_comb begin
        seen_d     = seen_q || cand_found;
        max_vld_d  = 1'b0;
        max_none_d = 1'b0;
        max_out_d  = max_out_q;
        if (query_done) begin
            seen_d     = 1'b0;
            max_vld_d  = 1'b1;
            max_none_d = !eff_seen;
            max_out_d  = eff_seen ? {eff_id, eff_score}
                                  : {{ID_WIDTH{1'b0}}, SCORE_WIDTH'(ZERO)};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rr_ptr_q   <= '0;
            overflow_q <= 1'b0;
            seen_q     <= 1'b0;
            max_vld_q  <= 1'b0;
            max_none_q <= 1'b0;
            max_out_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rr_ptr_q   <= rr_ptr_d;
            overflow_q <= overflow_d;
            seen_q     <= seen_d;
            max_vld_q  <= max_vld_d;
            max_none_q <= max_none_d;
            max_out_q  <= max_out_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (load[i]) begin
                hold_score_q[i] <= lane_score[i];
                hold_id_q[i]    <= lane_id[i];
            end
        end
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
        if (take_cand) begin
            best_score_q <= cand_score;
            best_id_q    <= cand_id;
        end
    end

    assign overflow = overflow_q;
    assign max_vld  = max_vld_q;
    assign max_none = max_none_q;
    assign max_out  = max_out_q;

endmodule
